// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding and timing defaults for the page scheduler
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        SHOW    = 2'd2
    } state_t;

    // One second of dwell at the board's 12 MHz clock
    localparam int DWELL_CYC_DEFAULT = 12_000_000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority finder: first valid index at or after start
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] start,
    output logic [W-1:0] pick,
    output logic         found
);

    int idx;

    // Walk from the farthest candidate back to start so the nearest valid one wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N;
            if (valid[idx[W-1:0]]) begin
                pick  = idx[W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_page_scheduler.sv
// rtl/seg_page_scheduler.sv - round-robin pager sharing a two-digit display among sources
module seg_page_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DWELL_CYC = DWELL_CYC_DEFAULT,
    parameter int IDX_W     = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic                 hold,
    input  logic                 next_req,
    output logic [3:0]           seg_data_1,
    output logic [3:0]           seg_data_2,
    output logic                 blank,
    output logic                 dp_2,
    output logic [IDX_W-1:0]     cur_src,
    output logic                 page_tick
);

    localparam int               CNT_W    = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [7:0]       src_byte [NUM_SRC];
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic             dwell_done;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_byte
        assign src_byte[i] = src_data[8*i +: 8];
    end

    // Search begins just past the current page so the current source is checked last
    assign search_start = (cur_src == IDX_LAST) ? '0 : cur_src + 1'b1;
    assign dwell_done   = !hold && (dwell_cnt == CNT_LAST);

    rr_pick #(
        .N (NUM_SRC),
        .W (IDX_W)
    ) u_rr_pick (
        .valid (src_valid),
        .start (search_start),
        .pick  (pick),
        .found (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|src_valid) state_nxt = ADVANCE;
            ADVANCE: state_nxt = found ? SHOW : IDLE;
            SHOW:    if (!src_valid[cur_src] || next_req || dwell_done) state_nxt = ADVANCE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_src    <= IDX_LAST;
            seg_data_1 <= 4'h0;
            seg_data_2 <= 4'h0;
            blank      <= 1'b1;
            dp_2       <= 1'b0;
            page_tick  <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            dp_2      <= hold;
            page_tick <= 1'b0;
            case (state)
                IDLE: begin
                    blank      <= 1'b1;
                    seg_data_1 <= 4'h0;
                    seg_data_2 <= 4'h0;
                end
                ADVANCE: begin
                    if (found) begin
                        cur_src    <= pick;
                        seg_data_1 <= src_byte[pick][7:4];
                        seg_data_2 <= src_byte[pick][3:0];
                        blank      <= 1'b0;
                        dwell_cnt  <= '0;
                        page_tick  <= 1'b1;
                    end else begin
                        blank      <= 1'b1;
                        seg_data_1 <= 4'h0;
                        seg_data_2 <= 4'h0;
                    end
                end
                SHOW: begin
                    seg_data_1 <= src_byte[cur_src][7:4];
                    seg_data_2 <= src_byte[cur_src][3:0];
                    // Stop counting on the exit edge so the count never passes DWELL_CYC-1
                    if (state_nxt == SHOW && !hold) dwell_cnt <= dwell_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_page_scheduler.sv
// tb/tb_seg_page_scheduler.sv - directed self-checking bench for seg_page_scheduler
module tb_seg_page_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic        hold;
    logic        next_req;
    logic [3:0]  seg_data_1;
    logic [3:0]  seg_data_2;
    logic        blank;
    logic        dp_2;
    logic [1:0]  cur_src;
    logic        page_tick;

    int checks;
    int errors;

    seg_page_scheduler #(
        .NUM_SRC   (4),
        .DWELL_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .hold       (hold),
        .next_req   (next_req),
        .seg_data_1 (seg_data_1),
        .seg_data_2 (seg_data_2),
        .blank      (blank),
        .dp_2       (dp_2),
        .cur_src    (cur_src),
        .page_tick  (page_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (page_tick !== 1'b1 && n < max);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({blank, seg_data_1, seg_data_2, cur_src, page_tick, dp_2} !== {1'b1, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got blank=%b seg=%h%h cur=%0d tick=%b dp=%b expected 1 00 3 0 0",
                     blank, seg_data_1, seg_data_2, cur_src, page_tick, dp_2);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({blank, cur_src, page_tick} !== {1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL idle_no_valid got blank=%b cur=%0d tick=%b expected 1 3 0", blank, cur_src, page_tick);
        end
    endtask

    task automatic test_full_rotation();
        logic [3:0] exp_s1 [4];
        logic [3:0] exp_s2 [4];
        int n;
        exp_s1 = '{4'h1, 4'h3, 4'h5, 4'h7};
        exp_s2 = '{4'h2, 4'h4, 4'h6, 4'h8};
        src_data  = 32'h7856_3412;
        src_valid = 4'b1111;
        tick();
        checks++;
        if (blank !== 1'b1 || page_tick !== 1'b0) begin
            errors++;
            $display("FAIL rot_advance_hold got blank=%b tick=%b expected 1 0", blank, page_tick);
        end
        tick();
        checks++;
        if ({cur_src, seg_data_1, seg_data_2, page_tick, blank} !== {2'd0, 4'h1, 4'h2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rot_first_page got cur=%0d seg=%h%h tick=%b blank=%b expected 0 12 1 0",
                     cur_src, seg_data_1, seg_data_2, page_tick, blank);
        end
        for (int p = 1; p <= 4; p++) begin
            wait_tick(20, n);
            checks++;
            if (n !== 9) begin
                errors++;
                $display("FAIL rot_period page=%0d got %0d cycles expected 9", p, n);
            end
            checks++;
            if (cur_src !== 2'(p % 4) || seg_data_1 !== exp_s1[p % 4] || seg_data_2 !== exp_s2[p % 4]) begin
                errors++;
                $display("FAIL rot_page page=%0d got cur=%0d seg=%h%h expected cur=%0d seg=%h%h",
                         p, cur_src, seg_data_1, seg_data_2, p % 4, exp_s1[p % 4], exp_s2[p % 4]);
            end
        end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_seq [3];
        int n;
        exp_seq = '{2'd2, 2'd0, 2'd2};
        src_valid = 4'b0101;
        for (int p = 0; p < 3; p++) begin
            wait_tick(20, n);
            checks++;
            if (n !== 9 || cur_src !== exp_seq[p]) begin
                errors++;
                $display("FAIL sparse_page step=%0d got cur=%0d after %0d cycles expected cur=%0d after 9",
                         p, cur_src, n, exp_seq[p]);
            end
        end
    endtask

    task automatic test_hold_next();
        int seen;
        int n;
        hold = 1'b1;
        tick();
        checks++;
        if (dp_2 !== 1'b1) begin
            errors++;
            $display("FAIL hold_dp got %b expected 1", dp_2);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (page_tick === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || cur_src !== 2'd2) begin
            errors++;
            $display("FAIL hold_frozen got ticks=%0d cur=%0d expected 0 2", seen, cur_src);
        end
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        checks++;
        if (cur_src !== 2'd2 || page_tick !== 1'b0) begin
            errors++;
            $display("FAIL next_latency1 got cur=%0d tick=%b expected 2 0", cur_src, page_tick);
        end
        tick();
        checks++;
        if (cur_src !== 2'd0 || page_tick !== 1'b1 || seg_data_1 !== 4'h1 || seg_data_2 !== 4'h2) begin
            errors++;
            $display("FAIL next_advance got cur=%0d tick=%b seg=%h%h expected 0 1 12",
                     cur_src, page_tick, seg_data_1, seg_data_2);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (page_tick === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || cur_src !== 2'd0) begin
            errors++;
            $display("FAIL hold_after_next got ticks=%0d cur=%0d expected 0 0", seen, cur_src);
        end
        hold = 1'b0;
        wait_tick(20, n);
        checks++;
        if (n !== 9 || cur_src !== 2'd2 || dp_2 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got cycles=%0d cur=%0d dp=%b expected 9 2 0", n, cur_src, dp_2);
        end
    endtask

    task automatic test_dropout();
        src_valid = 4'b0001;
        tick();
        checks++;
        if (cur_src !== 2'd2 || page_tick !== 1'b0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL drop_advance got cur=%0d tick=%b blank=%b expected 2 0 0", cur_src, page_tick, blank);
        end
        tick();
        checks++;
        if (cur_src !== 2'd0 || page_tick !== 1'b1 || seg_data_1 !== 4'h1 || seg_data_2 !== 4'h2) begin
            errors++;
            $display("FAIL drop_next_page got cur=%0d tick=%b seg=%h%h expected 0 1 12",
                     cur_src, page_tick, seg_data_1, seg_data_2);
        end
        src_valid = 4'b0000;
        repeat (2) tick();
        checks++;
        if ({blank, seg_data_1, seg_data_2, cur_src} !== {1'b1, 4'h0, 4'h0, 2'd0}) begin
            errors++;
            $display("FAIL drop_all got blank=%b seg=%h%h cur=%0d expected 1 00 0",
                     blank, seg_data_1, seg_data_2, cur_src);
        end
        src_valid = 4'b0010;
        tick();
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("FAIL reassert_early got blank=%b expected 1", blank);
        end
        tick();
        checks++;
        if ({cur_src, seg_data_1, seg_data_2, blank, page_tick} !== {2'd1, 4'h3, 4'h4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reassert_page got cur=%0d seg=%h%h blank=%b tick=%b expected 1 34 0 1",
                     cur_src, seg_data_1, seg_data_2, blank, page_tick);
        end
    endtask

    task automatic test_single();
        int n;
        src_data[23:16] = 8'h2A;
        src_valid = 4'b0100;
        repeat (2) tick();
        checks++;
        if ({cur_src, seg_data_1, seg_data_2, page_tick} !== {2'd2, 4'h2, 4'hA, 1'b1}) begin
            errors++;
            $display("FAIL single_first got cur=%0d seg=%h%h tick=%b expected 2 2a 1",
                     cur_src, seg_data_1, seg_data_2, page_tick);
        end
        for (int p = 0; p < 2; p++) begin
            wait_tick(20, n);
            checks++;
            if (n !== 9 || cur_src !== 2'd2) begin
                errors++;
                $display("FAIL single_repick step=%0d got cycles=%0d cur=%0d expected 9 2", p, n, cur_src);
            end
        end
        src_data[23:16] = 8'h2B;
        checks++;
        if (seg_data_2 !== 4'hA) begin
            errors++;
            $display("FAIL live_data_before got %h expected a", seg_data_2);
        end
        tick();
        checks++;
        if (seg_data_2 !== 4'hB || seg_data_1 !== 4'h2) begin
            errors++;
            $display("FAIL live_data_after got %h%h expected 2b", seg_data_1, seg_data_2);
        end
    endtask

    task automatic test_reset_mid_show();
        hold = 1'b1;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({blank, seg_data_1, seg_data_2, cur_src, page_tick, dp_2} !== {1'b1, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got blank=%b seg=%h%h cur=%0d tick=%b dp=%b expected 1 00 3 0 0",
                     blank, seg_data_1, seg_data_2, cur_src, page_tick, dp_2);
        end
        repeat (2) tick();
        checks++;
        if ({blank, cur_src, dp_2} !== {1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL reset_held got blank=%b cur=%0d dp=%b expected 1 3 0", blank, cur_src, dp_2);
        end
        rst  = 1'b0;
        hold = 1'b0;
        repeat (2) tick();
        checks++;
        if (cur_src !== 2'd2 || page_tick !== 1'b1 || blank !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_page got cur=%0d tick=%b blank=%b expected 2 1 0", cur_src, page_tick, blank);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        src_valid = 4'b0000;
        src_data  = 32'h0;
        hold      = 1'b0;
        next_req  = 1'b0;
        test_reset();
        test_full_rotation();
        test_sparse();
        test_hold_next();
        test_dropout();
        test_single();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
